// File: rtl/apb_lb_pkg.sv
// Shared types and elaboration helpers for the APB to local-bus bridge.
package apb_lb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_STRB_W = DEF_DATA_W / 8;

   function automatic int unsigned strb_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Smallest width (at least 1) able to hold 0..timeout, i.e. clog2(timeout+1).
   function automatic int unsigned cnt_width(input int unsigned timeout);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < (64'(timeout) + 64'd1)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_lb_wdog.sv
// Clearable wait-state watchdog: counts enabled cycles and flags the last
// permitted one. A TIMEOUT of 0 disables it entirely.
module apb_lb_wdog
   import apb_lb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned      CNT_W   = cnt_width(TIMEOUT);
   localparam logic             ENABLED = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TC_VAL  = ENABLED ? CNT_W'(TIMEOUT - 1) : '0;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && ENABLED) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = ENABLED && en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/apb_lb_bridge.sv
// APB4 completer bridging to a local-bus register port, with address-window
// decode, lb_rdyh-driven wait states and a PSLVERR-reporting watchdog.
module apb_lb_bridge
   import apb_lb_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          DATA_W    = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(32'h0000_0000),
   parameter logic [ADDR_W-1:0]    ADDR_MASK = ADDR_W'(32'hFFFF_F000),
   parameter int unsigned          TIMEOUT   = 16
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [DATA_W-1:0]     pwdata,
   input  logic [DATA_W/8-1:0]   pstrb,
   output logic                  pready,
   output logic [DATA_W-1:0]     prdata,
   output logic                  pslverr,
   output logic                  lb_cs,
   output logic                  lb_wrout,
   output logic [ADDR_W-1:0]     lb_aout,
   output logic [DATA_W-1:0]     lb_dout,
   output logic [DATA_W/8-1:0]   lb_be,
   input  logic                  lb_rdyh,
   input  logic [DATA_W-1:0]     lb_din
);

   localparam int unsigned STRB_W = strb_width(DATA_W);

   state_t              state_q,    state_d;
   logic                err_q,      err_d;
   logic                lb_cs_q,    lb_cs_d;
   logic                lb_wrout_q, lb_wrout_d;
   logic [ADDR_W-1:0]   lb_aout_q,  lb_aout_d;
   logic [DATA_W-1:0]   lb_dout_q,  lb_dout_d;
   logic [STRB_W-1:0]   lb_be_q,    lb_be_d;
   logic [DATA_W-1:0]   prdata_q,   prdata_d;

   logic                setup;
   logic                hit;
   logic                wd_tc;
   logic [STRB_W-1:0]   be_setup;

   assign setup = psel & ~penable;
   assign hit   = ((paddr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

   // Reads always enable every byte lane; writes follow the strobes as given.
   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_be
         assign be_setup[gi] = pwrite ? pstrb[gi] : 1'b1;
      end
   endgenerate

   apb_lb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i  (pclk),
      .srst_i (preset),
      .clr_i  (state_q != BUSY),
      .en_i   (state_q == BUSY),
      .tc_o   (wd_tc)
   );

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      lb_cs_d    = lb_cs_q;
      lb_wrout_d = lb_wrout_q;
      lb_aout_d  = lb_aout_q;
      lb_dout_d  = lb_dout_q;
      lb_be_d    = lb_be_q;
      prdata_d   = prdata_q;

      case (state_q)
         IDLE: begin
            lb_cs_d  = 1'b0;
            prdata_d = '0;
            err_d    = 1'b0;
            if (setup) begin
               lb_wrout_d = pwrite;
               lb_aout_d  = paddr;
               lb_dout_d  = pwdata;
               lb_be_d    = be_setup;
               if (hit) begin
                  state_d = BUSY;
                  lb_cs_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end

         BUSY: begin
            // A dropped psel mid-access is an aborted transfer: no response.
            if (!psel) begin
               state_d = IDLE;
               lb_cs_d = 1'b0;
            end else if (lb_rdyh) begin
               prdata_d = lb_wrout_q ? '0 : lb_din;
               err_d    = 1'b0;
               state_d  = RESP;
               lb_cs_d  = 1'b0;
            end else if (wd_tc) begin
               prdata_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
               lb_cs_d  = 1'b0;
            end
         end

         RESP: begin
            // Response flags live only for this one cycle.
            state_d  = IDLE;
            err_d    = 1'b0;
            prdata_d = '0;
            lb_cs_d  = 1'b0;
         end

         default: begin
            state_d  = IDLE;
            err_d    = 1'b0;
            prdata_d = '0;
            lb_cs_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q    <= IDLE;
         err_q      <= 1'b0;
         lb_cs_q    <= 1'b0;
         lb_wrout_q <= 1'b0;
         lb_aout_q  <= '0;
         lb_dout_q  <= '0;
         lb_be_q    <= '0;
         prdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         lb_cs_q    <= lb_cs_d;
         lb_wrout_q <= lb_wrout_d;
         lb_aout_q  <= lb_aout_d;
         lb_dout_q  <= lb_dout_d;
         lb_be_q    <= lb_be_d;
         prdata_q   <= prdata_d;
      end
   end

   assign pready   = (state_q == RESP);
   assign pslverr  = err_q;
   assign prdata   = prdata_q;
   assign lb_cs    = lb_cs_q;
   assign lb_wrout = lb_wrout_q;
   assign lb_aout  = lb_aout_q;
   assign lb_dout  = lb_dout_q;
   assign lb_be    = lb_be_q;

endmodule

// File: tb/tb_apb_lb_bridge.sv
// Directed, table-driven bench for apb_lb_bridge (default parameters).
module tb_apb_lb_bridge;

   logic        pclk;
   logic        preset;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic        lb_cs;
   logic        lb_wrout;
   logic [31:0] lb_aout;
   logic [31:0] lb_dout;
   logic [3:0]  lb_be;
   logic        lb_rdyh;
   logic [31:0] lb_din;

   int total_cnt = 0;
   int pass_cnt  = 0;

   apb_lb_bridge dut (
      .pclk     (pclk),
      .preset   (preset),
      .paddr    (paddr),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .pwdata   (pwdata),
      .pstrb    (pstrb),
      .pready   (pready),
      .prdata   (prdata),
      .pslverr  (pslverr),
      .lb_cs    (lb_cs),
      .lb_wrout (lb_wrout),
      .lb_aout  (lb_aout),
      .lb_dout  (lb_dout),
      .lb_be    (lb_be),
      .lb_rdyh  (lb_rdyh),
      .lb_din   (lb_din)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "simulation time limit");
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;      // BUSY cycles before lb_rdyh; >= 1000 means never
      logic [31:0] din;
      int          exp_busy;   // number of cycles lb_cs is seen high
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_be;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int waits, input logic [31:0] din,
                               input int exp_busy, input logic exp_err, input logic [31:0] exp_rdata,
                               input logic [3:0] exp_be);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.waits = waits; v.din = din;
      v.exp_busy = exp_busy; v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_be = exp_be;
      return v;
   endfunction

   task automatic do_xfer(input vec_t v, input int idx);
      int   busy_cnt;
      logic done;
      busy_cnt = 0;
      done     = 1'b0;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = v.wr;
      paddr   = v.addr;
      pwdata  = v.wdata;
      pstrb   = v.strb;
      lb_din  = v.din;
      lb_rdyh = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         tick();
         penable = 1'b1;
         if (pready) begin
            done = 1'b1;
         end else if (lb_cs) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
               check($sformatf("v%0d_wrout", idx), 64'(lb_wrout), 64'(v.wr));
               check($sformatf("v%0d_aout", idx), 64'(lb_aout), 64'(v.addr));
               check($sformatf("v%0d_be", idx), 64'(lb_be), 64'(v.exp_be));
               if (v.wr) check($sformatf("v%0d_dout", idx), 64'(lb_dout), 64'(v.wdata));
            end
            lb_rdyh = ((busy_cnt - 1) == v.waits);
         end else begin
            lb_rdyh = 1'b0;
         end
      end
      lb_rdyh = 1'b0;
      check($sformatf("v%0d_done", idx), 64'(done), 64'd1);
      check($sformatf("v%0d_busy_cycles", idx), 64'(busy_cnt), 64'(v.exp_busy));
      check($sformatf("v%0d_pslverr", idx), 64'(pslverr), 64'(v.exp_err));
      check($sformatf("v%0d_prdata", idx), 64'(prdata), 64'(v.exp_rdata));
      check($sformatf("v%0d_cs_in_resp", idx), 64'(lb_cs), 64'd0);
      tick();
      psel    = 1'b0;
      penable = 1'b0;
      check($sformatf("v%0d_pready_after", idx), 64'(pready), 64'd0);
      check($sformatf("v%0d_pslverr_after", idx), 64'(pslverr), 64'd0);
      $display("xfer %0d: wr=%0d addr=0x%08h busy=%0d pslverr=%0d prdata=0x%08h",
               idx, v.wr, v.addr, busy_cnt, v.exp_err, v.exp_rdata);
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = mk(1'b1, 32'h0000_0004, 32'hA5A5_1234, 4'hF,    0, 32'h0,         1, 1'b0, 32'h0,         4'hF);
      vecs[1]  = mk(1'b0, 32'h0000_0010, 32'h0,         4'h0,    3, 32'hDEAD_BEEF, 4, 1'b0, 32'hDEAD_BEEF, 4'hF);
      vecs[2]  = mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 1000, 32'h1234_5678, 16, 1'b1, 32'h0,        4'hF);
      vecs[3]  = mk(1'b1, 32'h0000_2000, 32'h5555_AAAA, 4'hF,    0, 32'h0,         0, 1'b1, 32'h0,         4'hF);
      vecs[4]  = mk(1'b1, 32'h0000_0008, 32'h1122_3344, 4'b0101, 1, 32'h0,         2, 1'b0, 32'h0,         4'b0101);
      vecs[5]  = mk(1'b0, 32'h0000_0008, 32'h0,         4'b0101, 0, 32'h0000_55AA, 1, 1'b0, 32'h0000_55AA, 4'hF);
      vecs[6]  = mk(1'b1, 32'h0000_000C, 32'h9999_0000, 4'h0,    0, 32'h0,         1, 1'b0, 32'h0,         4'h0);
      vecs[7]  = mk(1'b0, 32'h0000_0030, 32'h0,         4'h0,   15, 32'hCAFE_F00D, 16, 1'b0, 32'hCAFE_F00D, 4'hF);
      vecs[8]  = mk(1'b1, 32'h0000_0034, 32'h0BAD_0BAD, 4'hF, 1000, 32'h7777_7777, 16, 1'b1, 32'h0,        4'hF);
      vecs[9]  = mk(1'b0, 32'hFFFF_F010, 32'h0,         4'h0,    0, 32'h8888_8888, 0, 1'b1, 32'h0,         4'hF);
      vecs[10] = mk(1'b1, 32'h0000_0040, 32'h0102_0304, 4'hF,    0, 32'hFFFF_FFFF, 1, 1'b0, 32'h0,         4'hF);

      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; lb_rdyh = 1'b0; lb_din = '0;
      repeat (3) tick();
      check("rst_pready",   64'(pready),   64'd0);
      check("rst_pslverr",  64'(pslverr),  64'd0);
      check("rst_prdata",   64'(prdata),   64'd0);
      check("rst_lb_cs",    64'(lb_cs),    64'd0);
      check("rst_lb_wrout", 64'(lb_wrout), 64'd0);
      check("rst_lb_aout",  64'(lb_aout),  64'd0);
      check("rst_lb_dout",  64'(lb_dout),  64'd0);
      check("rst_lb_be",    64'(lb_be),    64'd0);
      preset = 1'b0;
      tick();

      // psel dropped during BUSY: abort, no response
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0010;
      tick();
      penable = 1'b1;
      check("abort_cs_busy", 64'(lb_cs), 64'd1);
      psel = 1'b0; penable = 1'b0;
      tick();
      check("abort_cs_low",   64'(lb_cs),  64'd0);
      check("abort_no_ready", 64'(pready), 64'd0);
      tick();
      check("abort_no_ready2", 64'(pready), 64'd0);
      $display("abort sequence done");

      for (int i = 0; i < 11; i++) begin
         do_xfer(vecs[i], i);
      end

      // reset asserted during the second BUSY cycle
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0004; lb_rdyh = 1'b0;
      tick();
      penable = 1'b1;
      tick();
      check("rstmid_cs_busy2", 64'(lb_cs), 64'd1);
      preset = 1'b1; psel = 1'b0; penable = 1'b0;
      tick();
      check("rstmid_cs",     64'(lb_cs),   64'd0);
      check("rstmid_pready", 64'(pready),  64'd0);
      check("rstmid_aout",   64'(lb_aout), 64'd0);
      preset = 1'b0;
      tick();
      check("rstmid_idle_pready", 64'(pready), 64'd0);
      $display("reset-mid-access sequence done");
      do_xfer(mk(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D, 4'hF), 11);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
